// File: rtl/alu_cmd_seq_if.sv
// Bus bundle for alu_cmd_seq: RX byte stream, register-file write port,
// ALU control/result and TX FIFO write side.
interface alu_cmd_seq_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_FUN_WIDTH = 4
);
    logic [DATA_WIDTH-1:0]    i_RX_P_DATA;
    logic                     i_RX_D_VLD;
    logic [2*DATA_WIDTH-1:0]  i_ALU_OUT;
    logic                     i_OUT_Valid;
    logic                     i_FIFO_FULL;
    logic                     o_WrEn;
    logic [ADDR_WIDTH-1:0]    o_Address;
    logic [DATA_WIDTH-1:0]    o_WrData;
    logic [ALU_FUN_WIDTH-1:0] o_ALU_FUN;
    logic                     o_ALU_EN;
    logic                     o_CLK_EN;
    logic [DATA_WIDTH-1:0]    o_FIFO_DATA;
    logic                     o_WR_INC;
    logic                     o_busy;
    logic                     o_err;

    modport master (
        output i_RX_P_DATA, i_RX_D_VLD, i_ALU_OUT, i_OUT_Valid, i_FIFO_FULL,
        input  o_WrEn, o_Address, o_WrData, o_ALU_FUN, o_ALU_EN, o_CLK_EN,
               o_FIFO_DATA, o_WR_INC, o_busy, o_err
    );

    modport slave (
        input  i_RX_P_DATA, i_RX_D_VLD, i_ALU_OUT, i_OUT_Valid, i_FIFO_FULL,
        output o_WrEn, o_Address, o_WrData, o_ALU_FUN, o_ALU_EN, o_CLK_EN,
               o_FIFO_DATA, o_WR_INC, o_busy, o_err
    );
endinterface

// File: rtl/alu_cmd_seq.sv
// ALU command sequencer: decodes 0xCC/0xDD from the RX stream, loads operands,
// runs the ALU and pushes the 16-bit result to the TX FIFO. Optional ALU_TIMEOUT_EN.
module alu_cmd_seq #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_FUN_WIDTH  = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic          i_CLK,
    input logic          i_RST,
    alu_cmd_seq_if.slave bus
);
    localparam logic [DATA_WIDTH-1:0] CMD_OPS  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_NOPS = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        OPA      = 4'd1,
        OPA_WR   = 4'd2,
        OPB      = 4'd3,
        OPB_WR   = 4'd4,
        FUN      = 4'd5,
        ALU_EXEC = 4'd6,
        FIFO_LO  = 4'd7,
        FIFO_HI  = 4'd8
    } state_t;

    state_t                    state_r;
    state_t                    state_nx_s;
    logic [DATA_WIDTH-1:0]     data_r;
    logic [ALU_FUN_WIDTH-1:0]  fun_r;
    logic [2*DATA_WIDTH-1:0]   res_r;
    logic                      timeout_s;

`ifdef ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
    logic [CNT_W-1:0] cnt_r;
    logic             err_r;

    assign timeout_s = (state_r == ALU_EXEC) && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Wait counter runs only while in ALU_EXEC; error flag is a one-cycle pulse
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            cnt_r <= '0;
            err_r <= 1'b0;
        end else begin
            cnt_r <= (state_r == ALU_EXEC) ? cnt_r + CNT_W'(1) : '0;
            err_r <= timeout_s && !bus.i_OUT_Valid;
        end
    end

    assign bus.o_err = err_r;
`else
    assign timeout_s = 1'b0;
    assign bus.o_err = 1'b0;
`endif

    // State register and data capture
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_r <= IDLE;
            data_r  <= '0;
            fun_r   <= '0;
            res_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            if (((state_r == OPA) || (state_r == OPB)) && bus.i_RX_D_VLD) begin
                data_r <= bus.i_RX_P_DATA;
            end
            if ((state_r == FUN) && bus.i_RX_D_VLD) begin
                fun_r <= bus.i_RX_P_DATA[ALU_FUN_WIDTH-1:0];
            end
            if ((state_r == ALU_EXEC) && bus.i_OUT_Valid) begin
                res_r <= bus.i_ALU_OUT;
            end
        end
    end

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.i_RX_D_VLD && (bus.i_RX_P_DATA == CMD_OPS)) begin
                    state_nx_s = OPA;
                end else if (bus.i_RX_D_VLD && (bus.i_RX_P_DATA == CMD_NOPS)) begin
                    state_nx_s = FUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            OPA:      state_nx_s = bus.i_RX_D_VLD ? OPA_WR : OPA;
            OPA_WR:   state_nx_s = OPB;
            OPB:      state_nx_s = bus.i_RX_D_VLD ? OPB_WR : OPB;
            OPB_WR:   state_nx_s = FUN;
            FUN:      state_nx_s = bus.i_RX_D_VLD ? ALU_EXEC : FUN;
            ALU_EXEC: begin
                // A result arriving on the expiry cycle takes priority over the timeout
                if (bus.i_OUT_Valid) begin
                    state_nx_s = FIFO_LO;
                end else if (timeout_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = ALU_EXEC;
                end
            end
            FIFO_LO:  state_nx_s = bus.i_FIFO_FULL ? FIFO_LO : FIFO_HI;
            FIFO_HI:  state_nx_s = bus.i_FIFO_FULL ? FIFO_HI : IDLE;
            default:  state_nx_s = IDLE;
        endcase
    end

    // Moore output decode; the FIFO strobe is additionally gated by FIFO full
    always_comb begin
        bus.o_WrEn      = 1'b0;
        bus.o_Address   = '0;
        bus.o_WrData    = '0;
        bus.o_ALU_EN    = 1'b0;
        bus.o_CLK_EN    = 1'b0;
        bus.o_FIFO_DATA = '0;
        bus.o_WR_INC    = 1'b0;
        case (state_r)
            OPA_WR: begin
                bus.o_WrEn   = 1'b1;
                bus.o_WrData = data_r;
            end
            OPB_WR: begin
                bus.o_WrEn    = 1'b1;
                bus.o_Address = ADDR_WIDTH'(1);
                bus.o_WrData  = data_r;
            end
            FUN: bus.o_CLK_EN = 1'b1;
            ALU_EXEC: begin
                bus.o_ALU_EN = 1'b1;
                bus.o_CLK_EN = 1'b1;
            end
            FIFO_LO: begin
                bus.o_FIFO_DATA = res_r[DATA_WIDTH-1:0];
                bus.o_WR_INC    = ~bus.i_FIFO_FULL;
            end
            FIFO_HI: begin
                bus.o_FIFO_DATA = res_r[2*DATA_WIDTH-1:DATA_WIDTH];
                bus.o_WR_INC    = ~bus.i_FIFO_FULL;
            end
            default: ;
        endcase
    end

    assign bus.o_ALU_FUN = fun_r;
    assign bus.o_busy    = (state_r != IDLE);
endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed self-checking bench for alu_cmd_seq; timeout checks depend on ALU_TIMEOUT_EN.
module tb_alu_cmd_seq;
    logic i_CLK = 1'b0;
    logic i_RST = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    logic [7:0] push_q[$];

    alu_cmd_seq_if bus();

    alu_cmd_seq dut (.i_CLK(i_CLK), .i_RST(i_RST), .bus(bus));

    always #5 i_CLK = ~i_CLK;

    // Record every RF write and FIFO push seen at the clock edge
    always @(posedge i_CLK) begin
        if (bus.o_WrEn) wr_cnt <= wr_cnt + 1;
        if (bus.o_WR_INC) push_q.push_back(bus.o_FIFO_DATA);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_CLK);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_RX_P_DATA = b;
        bus.i_RX_D_VLD  = 1'b1;
        tick();
        bus.i_RX_D_VLD  = 1'b0;
        bus.i_RX_P_DATA = 8'h00;
        #1;
    endtask

    task automatic chk_pushes(input string tag, input logic [7:0] lo, input logic [7:0] hi);
        chk({tag, "_npush"}, push_q.size(), 32'd2);
        if (push_q.size() == 2) begin
            chk({tag, "_lo"}, push_q[0], lo);
            chk({tag, "_hi"}, push_q[1], hi);
        end
        push_q.delete();
    endtask

    initial begin
        bus.i_RX_P_DATA = 8'h00;
        bus.i_RX_D_VLD  = 1'b0;
        bus.i_ALU_OUT   = 16'h0000;
        bus.i_OUT_Valid = 1'b0;
        bus.i_FIFO_FULL = 1'b0;
        tick();
        tick();
        i_RST = 1'b0;
        #1;
        chk("rst_busy", bus.o_busy, 32'd0);
        chk("rst_outs", {bus.o_WrEn, bus.o_ALU_EN, bus.o_CLK_EN, bus.o_WR_INC, bus.o_err}, 32'd0);
        chk("rst_fun", bus.o_ALU_FUN, 32'd0);
        push_q.delete();
        wr_cnt = 0;

        // 0xCC 0x05 0x03 0x00, ALU returns 0x0008
        send(8'hCC);
        chk("cc_busy", bus.o_busy, 32'd1);
        send(8'h05);
        chk("opa_wr", {bus.o_WrEn, bus.o_Address, bus.o_WrData}, {19'd0, 1'b1, 4'h0, 8'h05});
        tick();
        chk("opa_wr_1cyc", bus.o_WrEn, 32'd0);
        send(8'h03);
        chk("opb_wr", {bus.o_WrEn, bus.o_Address, bus.o_WrData}, {19'd0, 1'b1, 4'h1, 8'h03});
        tick();
        chk("fun_clken", {bus.o_CLK_EN, bus.o_ALU_EN, bus.o_WrEn}, 32'b100);
        send(8'h00);
        chk("exec_en", {bus.o_CLK_EN, bus.o_ALU_EN}, 32'b11);
        chk("exec_fun0", bus.o_ALU_FUN, 32'd0);
        bus.i_ALU_OUT = 16'h0008; bus.i_OUT_Valid = 1'b1;
        tick();
        bus.i_OUT_Valid = 1'b0; bus.i_ALU_OUT = 16'hFFFF;
        #1;
        chk("cc_lo", {bus.o_WR_INC, bus.o_FIFO_DATA}, {23'd0, 1'b1, 8'h08});
        tick();
        chk("cc_hi", {bus.o_WR_INC, bus.o_FIFO_DATA}, {23'd0, 1'b1, 8'h00});
        tick();
        chk("cc_idle", bus.o_busy, 32'd0);
        chk("cc_rfwr", wr_cnt, 32'd2);
        chk_pushes("cc", 8'h08, 8'h00);

        // 0xDD 0x02, ALU returns 0x1234 on the first exec cycle
        send(8'hDD);
        chk("dd_clken", bus.o_CLK_EN, 32'd1);
        send(8'h02);
        bus.i_ALU_OUT = 16'h1234; bus.i_OUT_Valid = 1'b1;
        #1;
        chk("dd_fun2", bus.o_ALU_FUN, 32'd2);
        chk("dd_exec", bus.o_ALU_EN, 32'd1);
        tick();
        bus.i_OUT_Valid = 1'b0;
        #1;
        chk("dd_lo", {bus.o_WR_INC, bus.o_FIFO_DATA}, {23'd0, 1'b1, 8'h34});
        tick();
        chk("dd_hi", {bus.o_WR_INC, bus.o_FIFO_DATA}, {23'd0, 1'b1, 8'h12});
        tick();
        chk("dd_idle", bus.o_busy, 32'd0);
        chk("dd_nowr", wr_cnt, 32'd2);
        chk_pushes("dd", 8'h34, 8'h12);

        // FIFO full for 5 cycles on entering FIFO_LO
        send(8'hDD);
        send(8'h09);
        bus.i_ALU_OUT = 16'hBEEF; bus.i_OUT_Valid = 1'b1; bus.i_FIFO_FULL = 1'b1;
        tick();
        bus.i_OUT_Valid = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("full_hold", {bus.o_WR_INC, bus.o_FIFO_DATA, bus.o_busy}, {23'd0, 1'b0, 8'hEF, 1'b1});
            if (i < 4) tick();
        end
        tick();
        bus.i_FIFO_FULL = 1'b0;
        #1;
        chk("full_lo", {bus.o_WR_INC, bus.o_FIFO_DATA}, {23'd0, 1'b1, 8'hEF});
        tick();
        chk("full_hi", {bus.o_WR_INC, bus.o_FIFO_DATA}, {23'd0, 1'b1, 8'hBE});
        tick();
        chk("full_idle", bus.o_busy, 32'd0);
        chk_pushes("full", 8'hEF, 8'hBE);

        // Non-ALU bytes in IDLE are ignored
        send(8'hAA);
        send(8'hBB);
        send(8'h55);
        chk("junk_state", {bus.o_busy, bus.o_WrEn, bus.o_CLK_EN, bus.o_ALU_EN, bus.o_WR_INC}, 32'd0);
        chk("junk_funhold", bus.o_ALU_FUN, 32'd9);
        chk("junk_nopush", push_q.size(), 32'd0);

        // Reset while in OPB, then a normal 0xDD command
        send(8'hCC);
        send(8'h07);
        tick();
        chk("opb_busy", bus.o_busy, 32'd1);
        i_RST = 1'b1;
        tick();
        i_RST = 1'b0;
        #1;
        chk("mid_rst", {bus.o_busy, bus.o_WrEn, bus.o_Address, bus.o_WrData, bus.o_ALU_FUN,
                        bus.o_CLK_EN, bus.o_ALU_EN, bus.o_FIFO_DATA, bus.o_WR_INC}, 32'd0);
        wr_cnt = 0;
        send(8'h44);
        chk("rst_drop", wr_cnt, 32'd0);
        send(8'hDD);
        send(8'h01);
        send(8'hCC);
        chk("exec_drop", {bus.o_ALU_EN, bus.o_ALU_FUN}, {27'd0, 1'b1, 4'h1});
        bus.i_ALU_OUT = 16'hA55A; bus.i_OUT_Valid = 1'b1;
        tick();
        bus.i_OUT_Valid = 1'b0;
        tick();
        tick();
        chk("post_rst_idle", bus.o_busy, 32'd0);
        chk_pushes("post_rst", 8'h5A, 8'hA5);

        // ALU never answers
        send(8'hDD);
        send(8'h03);
`ifdef ALU_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        chk("to_wait", {bus.o_ALU_EN, bus.o_err}, 32'b10);
        tick();
        chk("to_err", {bus.o_err, bus.o_busy, bus.o_WR_INC}, 32'b100);
        tick();
        chk("to_err_pulse", bus.o_err, 32'd0);
`else
        for (int i = 0; i < 40; i++) tick();
        chk("to_stay", {bus.o_ALU_EN, bus.o_busy, bus.o_err}, 32'b110);
        i_RST = 1'b1;
        tick();
        i_RST = 1'b0;
        #1;
`endif
        chk("to_nopush", push_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
